// File: rtl/alu_control_sequencer.sv
// Five-state FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer for a simple ALU datapath.
// Strobes decode from the registered state and latched opcode; branch flags feed only the taken register.
module alu_control_sequencer (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] Instruction,
  input  logic        MFC,
  input  logic        Zero_In,
  input  logic        Negative_In,
  input  logic        Overflow_In,
  input  logic        Carry_In,
  output logic [31:0] ALU_Op,
  output logic        IR_Enable,
  output logic        PC_Enable,
  output logic        MEM_Read,
  output logic        MEM_Write,
  output logic        MuxB_Imm,
  output logic        RZ_Enable,
  output logic        RF_Write,
  output logic        PC_Load,
  output logic [31:0] CCR_Out,
  output logic        NOP_FLAG,
  output logic        INR_FLAG,
  output logic [2:0]  Stage
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_run;
  logic [6:0]  r_op;
  logic        r_taken;
  logic [3:0]  r_ccr_lo;
  logic        r_nop;
  logic        r_inr;
  logic [6:0]  w_dec_op;
  logic        w_cond;
  logic        w_unused;

  assign w_dec_op = Instruction[6:0];
  assign w_unused = ^Instruction[31:7];

  function automatic logic f_valid(input logic [6:0] op);
    return op inside {[7'd0:7'd18], [7'd32:7'd45], 7'd64, 7'd65};
  endfunction

  function automatic logic f_load(input logic [6:0] op);
    return op inside {7'd14, 7'd15, 7'd32, 7'd33, 7'd42, 7'd44};
  endfunction

  function automatic logic f_store(input logic [6:0] op);
    return op inside {7'd43, 7'd45};
  endfunction

  function automatic logic f_flags(input logic [6:0] op);
    return op inside {[7'd1:7'd12], [7'd34:7'd38]};
  endfunction

  function automatic logic f_rz(input logic [6:0] op);
    return op inside {[7'd1:7'd15], [7'd32:7'd38], [7'd42:7'd45]};
  endfunction

  function automatic logic f_rf(input logic [6:0] op);
    return op inside {[7'd1:7'd15], [7'd32:7'd38], 7'd42, 7'd44, 7'd17, 7'd65};
  endfunction

  always_comb begin
    w_cond = 1'b0;
    case (r_op)
      7'd39:                               w_cond = Zero_In;
      7'd40:                               w_cond = !Zero_In;
      7'd41:                               w_cond = Negative_In ^ Overflow_In;
      7'd16, 7'd17, 7'd18, 7'd64, 7'd65:  w_cond = 1'b1;
      default:                             w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = (r_run && MFC) ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = (!f_valid(w_dec_op) || w_dec_op == 7'd0) ? S_FETCH : S_EXECUTE;
      S_EXECUTE:   w_next = (f_load(r_op) || f_store(r_op)) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    w_next = MFC ? S_WRITEBACK : S_MEMORY;
      S_WRITEBACK: w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // r_run holds off the first fetch request until one clock edge has passed after reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_FETCH;
      r_run    <= 1'b0;
      r_op     <= 7'd0;
      r_taken  <= 1'b0;
      r_ccr_lo <= 4'd0;
      r_nop    <= 1'b0;
      r_inr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (r_state == S_DECODE) begin
        r_op    <= w_dec_op;
        r_taken <= 1'b0;
        if (!f_valid(w_dec_op)) begin
          r_inr <= 1'b1;
        end else if (w_dec_op == 7'd0) begin
          r_nop <= 1'b1;
          r_inr <= 1'b0;
        end else begin
          r_nop <= 1'b0;
          r_inr <= 1'b0;
        end
      end
      if (r_state == S_EXECUTE) begin
        r_taken <= w_cond;
        if (f_flags(r_op))
          r_ccr_lo <= {Zero_In, Overflow_In, Negative_In, Carry_In};
      end
    end
  end

  always_comb begin
    IR_Enable = r_run && (r_state == S_FETCH) && MFC;
    PC_Enable = IR_Enable;
    MEM_Read  = r_run && ((r_state == S_FETCH) || ((r_state == S_MEMORY) && f_load(r_op)));
    MEM_Write = (r_state == S_MEMORY) && f_store(r_op);
    ALU_Op    = (r_state == S_EXECUTE) ? {25'd0, r_op} : 32'd0;
    MuxB_Imm  = (r_state == S_EXECUTE) && (r_op inside {[7'd32:7'd45]});
    RZ_Enable = (r_state == S_EXECUTE) && f_rz(r_op);
    RF_Write  = (r_state == S_WRITEBACK) && f_rf(r_op);
    PC_Load   = (r_state == S_WRITEBACK) && r_taken;
  end

  assign CCR_Out  = {25'd0, r_nop, 1'b0, r_inr, r_ccr_lo};
  assign NOP_FLAG = r_nop;
  assign INR_FLAG = r_inr;
  assign Stage    = r_state;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: fixed instruction sequence with hand-computed
// per-cycle expectations, sampled on the falling clock edge.
module tb_alu_control_sequencer;

  logic        Clock;
  logic        Reset_n;
  logic [31:0] Instruction;
  logic        MFC;
  logic        Zero_In, Negative_In, Overflow_In, Carry_In;
  logic [31:0] ALU_Op;
  logic        IR_Enable, PC_Enable, MEM_Read, MEM_Write, MuxB_Imm;
  logic        RZ_Enable, RF_Write, PC_Load;
  logic [31:0] CCR_Out;
  logic        NOP_FLAG, INR_FLAG;
  logic [2:0]  Stage;

  int n_checks = 0;
  int n_errors = 0;

  alu_control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Instruction(Instruction), .MFC(MFC),
    .Zero_In(Zero_In), .Negative_In(Negative_In), .Overflow_In(Overflow_In), .Carry_In(Carry_In),
    .ALU_Op(ALU_Op), .IR_Enable(IR_Enable), .PC_Enable(PC_Enable),
    .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MuxB_Imm(MuxB_Imm),
    .RZ_Enable(RZ_Enable), .RF_Write(RF_Write), .PC_Load(PC_Load),
    .CCR_Out(CCR_Out), .NOP_FLAG(NOP_FLAG), .INR_FLAG(INR_FLAG), .Stage(Stage)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
  endtask

  initial begin
    Reset_n = 1'b0; Instruction = 32'd1; MFC = 1'b1;
    Zero_In = 1'b0; Overflow_In = 1'b1; Negative_In = 1'b1; Carry_In = 1'b0;
    #3;
    chk("rst_stage", {29'd0, Stage}, 32'd0);
    chk("rst_ccr", CCR_Out, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_Read}, 32'd0);
    chk("rst_ir_en", {31'd0, IR_Enable}, 32'd0);
    cyc();            // t=10
    #2 Reset_n = 1'b1; // t=12
    #1 chk("post_rst_no_read", {31'd0, MEM_Read}, 32'd0);

    // ADD (1): Z=0 V=1 N=1 C=0
    cyc(); // t=20 FETCH
    chk("add_f_stage", {29'd0, Stage}, 32'd0);
    chk("add_f_read", {31'd0, MEM_Read}, 32'd1);
    chk("add_f_ir", {31'd0, IR_Enable}, 32'd1);
    chk("add_f_pc", {31'd0, PC_Enable}, 32'd1);
    cyc(); // DECODE
    chk("add_d_stage", {29'd0, Stage}, 32'd1);
    chk("add_d_aluop", ALU_Op, 32'd0);
    cyc(); // EXECUTE
    chk("add_e_stage", {29'd0, Stage}, 32'd2);
    chk("add_e_rz", {31'd0, RZ_Enable}, 32'd1);
    chk("add_e_aluop", ALU_Op, 32'd1);
    chk("add_e_muxb", {31'd0, MuxB_Imm}, 32'd0);
    cyc(); // WRITEBACK
    chk("add_w_stage", {29'd0, Stage}, 32'd4);
    chk("add_w_rf", {31'd0, RF_Write}, 32'd1);
    chk("add_w_ccr", CCR_Out, 32'h06);
    chk("add_w_pcload", {31'd0, PC_Load}, 32'd0);

    // BEQ (39) taken
    cyc(); // t=60 FETCH
    chk("beq1_f_stage", {29'd0, Stage}, 32'd0);
    Instruction = 32'd39; Zero_In = 1'b1;
    cyc(); cyc(); // EXECUTE
    chk("beq1_e_aluop", ALU_Op, 32'd39);
    chk("beq1_e_muxb", {31'd0, MuxB_Imm}, 32'd1);
    chk("beq1_e_rz", {31'd0, RZ_Enable}, 32'd0);
    cyc(); // WRITEBACK
    chk("beq1_w_pcload", {31'd0, PC_Load}, 32'd1);
    chk("beq1_w_rf", {31'd0, RF_Write}, 32'd0);
    chk("beq1_w_ccr", CCR_Out, 32'h06);

    // BEQ not taken
    cyc(); // t=100 FETCH
    Zero_In = 1'b0;
    cyc(); cyc(); cyc(); // WRITEBACK
    chk("beq0_w_stage", {29'd0, Stage}, 32'd4);
    chk("beq0_w_pcload", {31'd0, PC_Load}, 32'd0);
    chk("beq0_w_ccr", CCR_Out, 32'h06);

    // LD# (32) with MFC arriving on the third MEMORY cycle
    cyc(); // t=140 FETCH
    Instruction = 32'd32;
    cyc(); // DECODE
    MFC = 1'b0;
    cyc(); // EXECUTE
    chk("ld_e_muxb", {31'd0, MuxB_Imm}, 32'd1);
    chk("ld_e_rz", {31'd0, RZ_Enable}, 32'd1);
    chk("ld_e_read", {31'd0, MEM_Read}, 32'd0);
    cyc(); // MEMORY 1
    chk("ld_m1_stage", {29'd0, Stage}, 32'd3);
    chk("ld_m1_read", {31'd0, MEM_Read}, 32'd1);
    chk("ld_m1_write", {31'd0, MEM_Write}, 32'd0);
    cyc(); // MEMORY 2
    chk("ld_m2_read", {31'd0, MEM_Read}, 32'd1);
    chk("ld_m2_rf", {31'd0, RF_Write}, 32'd0);
    cyc(); // MEMORY 3
    chk("ld_m3_read", {31'd0, MEM_Read}, 32'd1);
    MFC = 1'b1;
    cyc(); // WRITEBACK
    chk("ld_w_stage", {29'd0, Stage}, 32'd4);
    chk("ld_w_rf", {31'd0, RF_Write}, 32'd1);
    chk("ld_w_read", {31'd0, MEM_Read}, 32'd0);

    // Invalid opcode 0x7F, then ADD clears INR
    cyc(); // t=210 FETCH
    Instruction = 32'h7F;
    cyc(); // DECODE
    chk("inv_d_stage", {29'd0, Stage}, 32'd1);
    cyc(); // back in FETCH
    chk("inv_stage", {29'd0, Stage}, 32'd0);
    chk("inv_ccr", CCR_Out, 32'h16);
    chk("inv_inr", {31'd0, INR_FLAG}, 32'd1);
    chk("inv_rf", {31'd0, RF_Write}, 32'd0);
    Instruction = 32'd1;
    cyc(); // DECODE
    chk("add2_d_inr", {31'd0, INR_FLAG}, 32'd1);
    cyc(); // EXECUTE
    chk("add2_e_inr", {31'd0, INR_FLAG}, 32'd0);
    chk("add2_e_ccr", CCR_Out, 32'h06);
    cyc(); // WRITEBACK

    // NOP
    cyc(); // t=270 FETCH
    Instruction = 32'd0;
    cyc(); // DECODE
    cyc(); // FETCH
    chk("nop_stage", {29'd0, Stage}, 32'd0);
    chk("nop_flag", {31'd0, NOP_FLAG}, 32'd1);
    chk("nop_ccr", CCR_Out, 32'h46);

    // STIX (45), reset during MEMORY wait
    Instruction = 32'd45;
    cyc(); // DECODE
    cyc(); // EXECUTE
    chk("stix_e_muxb", {31'd0, MuxB_Imm}, 32'd1);
    chk("stix_e_rz", {31'd0, RZ_Enable}, 32'd1);
    MFC = 1'b0;
    cyc(); // MEMORY
    chk("stix_m_write", {31'd0, MEM_Write}, 32'd1);
    chk("stix_m_read", {31'd0, MEM_Read}, 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("stix_rst_write", {31'd0, MEM_Write}, 32'd0);
    chk("stix_rst_stage", {29'd0, Stage}, 32'd0);
    chk("stix_rst_ccr", CCR_Out, 32'd0);
    chk("stix_rst_nop", {31'd0, NOP_FLAG}, 32'd0);
    #9 Reset_n = 1'b1; MFC = 1'b1;
    #1 chk("rerst_no_read", {31'd0, MEM_Read}, 32'd0);
    cyc();
    chk("rerst_read", {31'd0, MEM_Read}, 32'd1);
    chk("rerst_stage", {29'd0, Stage}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
